tlb_controller: RTL and testbench

- Sequences the 32-entry TLB: owns the 32x20 key (virtual page) array and drives both ports of the 32x22 TLB value memory.
- Port 1 of the value memory serves the translation pipeline; port 2 serves management commands (probe, indexed read, indexed write, random write) from the CPU control unit.
- Arbitrates key-array writes against in-flight translations and maintains the random-replacement counter.

---
 rtl/tlb_pkg.sv | 34 +++
 rtl/tlb_key_matcher.sv | 23 ++
 rtl/tlb_controller.sv | 160 ++++++++++++++++
 tb/tb_tlb_controller.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tlb_pkg.sv
// Shared encodings and geometry for the TLB controller and its key matcher.
package tlb_pkg;

  localparam int TLB_ENTRY_COUNT = 32;
  localparam int TLB_INDEX_W     = 5;
  localparam int TLB_KEY_W       = 20;
  localparam int TLB_VALUE_W     = 22;

  localparam logic [TLB_INDEX_W-1:0] TLB_RANDOM_MIN = 5'd4;
  localparam logic [TLB_INDEX_W-1:0] TLB_RANDOM_MAX = 5'(TLB_ENTRY_COUNT - 1);
  localparam logic [TLB_KEY_W-1:0]   TLB_KEY_RESET  = 20'hC0000;

  // Value word layout: {frame[19:0], W, V}
  localparam int TLB_V_BIT     = 0;
  localparam int TLB_W_BIT     = 1;
  localparam int TLB_FRAME_LSB = 2;
  localparam int TLB_FRAME_MSB = 21;

  typedef enum logic [1:0] {
    TLB_OP_PROBE         = 2'd0,
    TLB_OP_READ          = 2'd1,
    TLB_OP_WRITE_INDEXED = 2'd2,
    TLB_OP_WRITE_RANDOM  = 2'd3
  } tlb_op_t;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_READ_WAIT = 2'd1,
    ST_RESPOND   = 2'd2
  } tlb_state_t;

  typedef logic [TLB_ENTRY_COUNT-1:0][TLB_KEY_W-1:0] tlb_key_array_t;

endpackage

// File: rtl/tlb_key_matcher.sv
// Combinational compare of one page against every key; lowest matching index wins.
module tlb_key_matcher
  import tlb_pkg::*;
(
  input  tlb_key_array_t         keys,
  input  logic [TLB_KEY_W-1:0]   page,
  output logic                   hit,
  output logic [TLB_INDEX_W-1:0] index
);

  // Scanning downward lets the lowest matching entry overwrite higher ones.
  always_comb begin
    hit   = 1'b0;
    index = '0;
    for (int i = TLB_ENTRY_COUNT - 1; i >= 0; i--) begin
      if (keys[i] == page) begin
        hit   = 1'b1;
        index = TLB_INDEX_W'(i);
      end
    end
  end

endmodule

// File: rtl/tlb_controller.sv
// TLB sequencer: key array, translation pipeline on value-memory port 1,
// management command FSM on port 2, and the random-replacement counter.
module tlb_controller
  import tlb_pkg::*;
(
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   transRequest,
  input  logic [TLB_KEY_W-1:0]   transPage,
  output logic                   transAccept,
  output logic                   transDone,
  output logic                   transMiss,
  output logic [19:0]            transFrame,
  output logic                   transWritable,
  output logic                   transValid,
  input  logic                   cmdValid,
  input  logic [1:0]             cmdOp,
  input  logic [TLB_INDEX_W-1:0] cmdIndex,
  input  logic [TLB_KEY_W-1:0]   cmdKey,
  input  logic [TLB_VALUE_W-1:0] cmdValue,
  output logic                   cmdReady,
  output logic                   rspValid,
  output logic [TLB_INDEX_W-1:0] rspIndex,
  output logic [TLB_KEY_W-1:0]   rspKey,
  output logic [TLB_VALUE_W-1:0] rspValue,
  output logic                   rspProbeMiss,
  output logic [TLB_INDEX_W-1:0] randomIndex,
  output logic [TLB_INDEX_W-1:0] vmIndex1,
  input  logic [TLB_VALUE_W-1:0] vmReadData1,
  output logic [TLB_INDEX_W-1:0] vmIndex2,
  input  logic [TLB_VALUE_W-1:0] vmReadData2,
  output logic [TLB_VALUE_W-1:0] vmWriteData2,
  output logic                   vmWriteEnable2
);

  // Command handshake: a command transfers on a rising edge where cmdValid and
  // cmdReady are both high; cmdReady is high only in IDLE, and rspValid pulses
  // for exactly one cycle when the command completes.

  tlb_state_t             state, state_next;
  tlb_key_array_t         keys;
  tlb_op_t                op;
  logic [TLB_INDEX_W-1:0] random_q;
  logic                   trans_done_q, trans_miss_q;
  logic [TLB_INDEX_W-1:0] rsp_index_q;
  logic                   rsp_miss_q;
  logic [TLB_KEY_W-1:0]   rsp_key_q;

  logic                   trans_hit, probe_hit;
  logic [TLB_INDEX_W-1:0] trans_index, probe_index;
  logic                   cmd_accept, write_commit;
  logic [TLB_INDEX_W-1:0] write_index;

  assign op           = tlb_op_t'(cmdOp);
  assign cmd_accept   = (state == ST_IDLE) && cmdValid;
  assign write_commit = cmd_accept && ((op == TLB_OP_WRITE_INDEXED) || (op == TLB_OP_WRITE_RANDOM));
  assign write_index  = (op == TLB_OP_WRITE_RANDOM) ? random_q : cmdIndex;

  tlb_key_matcher u_trans_match (
    .keys  (keys),
    .page  (transPage),
    .hit   (trans_hit),
    .index (trans_index)
  );

  tlb_key_matcher u_probe_match (
    .keys  (keys),
    .page  (cmdKey),
    .hit   (probe_hit),
    .index (probe_index)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= ST_IDLE;
      random_q     <= TLB_RANDOM_MAX;
      trans_done_q <= 1'b0;
      trans_miss_q <= 1'b0;
      rsp_index_q  <= '0;
      rsp_miss_q   <= 1'b0;
      rsp_key_q    <= '0;
      for (int i = 0; i < TLB_ENTRY_COUNT; i++) keys[i] <= TLB_KEY_RESET;
    end else begin
      state        <= state_next;
      random_q     <= (random_q == TLB_RANDOM_MIN) ? TLB_RANDOM_MAX : random_q - 5'd1;
      trans_done_q <= transAccept;
      trans_miss_q <= !trans_hit;
      if (cmd_accept) begin
        rsp_miss_q <= 1'b0;
        case (op)
          TLB_OP_PROBE: begin
            rsp_index_q <= probe_index;
            rsp_miss_q  <= !probe_hit;
          end
          TLB_OP_READ: begin
            rsp_index_q <= cmdIndex;
            rsp_key_q   <= keys[cmdIndex];
          end
          default: begin
            rsp_index_q       <= write_index;
            keys[write_index] <= cmdKey;
          end
        endcase
      end
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (cmdValid) state_next = (op == TLB_OP_READ) ? ST_READ_WAIT : ST_RESPOND;
      end
      ST_READ_WAIT: state_next = ST_IDLE;
      ST_RESPOND:   state_next = ST_IDLE;
      default:      state_next = ST_IDLE;
    endcase
  end

  // Outputs are qualified by !reset so a pending response or result never
  // escapes during the reset cycle itself.
  always_comb begin
    cmdReady       = (state == ST_IDLE);
    rspValid       = !reset && ((state == ST_READ_WAIT) || (state == ST_RESPOND));
    rspIndex       = rspValid ? rsp_index_q : '0;
    rspKey         = '0;
    rspValue       = '0;
    rspProbeMiss   = !reset && (state == ST_RESPOND) && rsp_miss_q;
    vmIndex2       = '0;
    vmWriteData2   = '0;
    vmWriteEnable2 = 1'b0;
    if (!reset && (state == ST_READ_WAIT)) begin
      rspKey   = rsp_key_q;
      rspValue = vmReadData2;
    end
    if (cmd_accept && (op == TLB_OP_READ)) vmIndex2 = cmdIndex;
    if (write_commit && !reset) begin
      vmIndex2       = write_index;
      vmWriteData2   = cmdValue;
      vmWriteEnable2 = 1'b1;
    end

    // Port 1 is never read in a commit cycle, so translations see writes one cycle later.
    transAccept   = transRequest && !write_commit;
    vmIndex1      = transAccept ? trans_index : '0;
    transDone     = trans_done_q && !reset;
    transMiss     = transDone && trans_miss_q;
    transFrame    = '0;
    transWritable = 1'b0;
    transValid    = 1'b0;
    if (transDone && !trans_miss_q) begin
      transFrame    = vmReadData1[TLB_FRAME_MSB:TLB_FRAME_LSB];
      transWritable = vmReadData1[TLB_W_BIT];
      transValid    = vmReadData1[TLB_V_BIT];
    end
  end

  assign randomIndex = random_q;

endmodule

// File: tb/tb_tlb_controller.sv
// Scoreboard bench for tlb_controller: a table-based TLB model predicts every
// translation result and command response; a negedge monitor compares them.
module tb_tlb_controller;

  logic        clock = 1'b0;
  logic        reset;
  logic        transRequest;
  logic [19:0] transPage;
  logic        transAccept, transDone, transMiss, transWritable, transValid;
  logic [19:0] transFrame;
  logic        cmdValid;
  logic [1:0]  cmdOp;
  logic [4:0]  cmdIndex;
  logic [19:0] cmdKey;
  logic [21:0] cmdValue;
  logic        cmdReady, rspValid, rspProbeMiss;
  logic [4:0]  rspIndex, randomIndex, vmIndex1, vmIndex2;
  logic [19:0] rspKey;
  logic [21:0] rspValue, vmReadData1, vmReadData2, vmWriteData2;
  logic        vmWriteEnable2;

  tlb_controller dut (
    .clock(clock), .reset(reset),
    .transRequest(transRequest), .transPage(transPage), .transAccept(transAccept),
    .transDone(transDone), .transMiss(transMiss), .transFrame(transFrame),
    .transWritable(transWritable), .transValid(transValid),
    .cmdValid(cmdValid), .cmdOp(cmdOp), .cmdIndex(cmdIndex), .cmdKey(cmdKey),
    .cmdValue(cmdValue), .cmdReady(cmdReady), .rspValid(rspValid), .rspIndex(rspIndex),
    .rspKey(rspKey), .rspValue(rspValue), .rspProbeMiss(rspProbeMiss),
    .randomIndex(randomIndex), .vmIndex1(vmIndex1), .vmReadData1(vmReadData1),
    .vmIndex2(vmIndex2), .vmReadData2(vmReadData2), .vmWriteData2(vmWriteData2),
    .vmWriteEnable2(vmWriteEnable2)
  );

  // ---------------- clock / value memory / cycle counters
  always #5 clock = ~clock;

  logic [21:0] vm_mem [32];
  always @(posedge clock) begin
    if (vmWriteEnable2) vm_mem[vmIndex2] <= vmWriteData2;
    vmReadData1 <= vm_mem[vmIndex1];
    vmReadData2 <= vm_mem[vmIndex2];
  end

  int cyc = 0;
  int since_rst = 0;
  always @(posedge clock) begin
    cyc <= cyc + 1;
    since_rst <= reset ? 0 : since_rst + 1;
  end

  // ---------------- reference model
  logic [19:0] ref_keys [32];
  logic [21:0] ref_vals [32];
  logic        ref_busy;

  function automatic int ref_lookup(input logic [19:0] page);
    for (int i = 0; i < 32; i++) if (ref_keys[i] == page) return i;
    return -1;
  endfunction

  function automatic logic [4:0] exp_random();
    return 5'(31 - (since_rst % 28));
  endfunction

  // ---------------- scoreboard
  typedef struct packed {
    logic [31:0] due;
    logic        miss;
    logic [19:0] frame;
    logic        w;
    logic        v;
  } trans_exp_t;

  typedef struct packed {
    logic [31:0] due;
    logic [1:0]  op;
    logic [4:0]  idx;
    logic [19:0] key;
    logic [21:0] value;
    logic        miss;
  } rsp_exp_t;

  trans_exp_t trans_q [$];
  rsp_exp_t   rsp_q [$];
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clock) begin
    trans_exp_t te;
    rsp_exp_t   re;
    if (transDone) begin
      if (trans_q.size() == 0) check("trans_done_unexpected", {31'b0, transDone}, 0);
      else begin
        te = trans_q.pop_front();
        check("trans_latency", cyc, te.due);
        check("trans_miss", {31'b0, transMiss}, {31'b0, te.miss});
        check("trans_frame", {12'b0, transFrame}, {12'b0, te.frame});
        check("trans_w", {31'b0, transWritable}, {31'b0, te.w});
        check("trans_v", {31'b0, transValid}, {31'b0, te.v});
      end
    end else if (trans_q.size() > 0 && trans_q[0].due <= cyc) begin
      void'(trans_q.pop_front());
      check("trans_done_missing", {31'b0, transDone}, 1);
    end
    if (rspValid) begin
      if (rsp_q.size() == 0) check("rsp_valid_unexpected", {31'b0, rspValid}, 0);
      else begin
        re = rsp_q.pop_front();
        check("rsp_latency", cyc, re.due);
        check("rsp_probe_miss", {31'b0, rspProbeMiss}, {31'b0, re.miss});
        if (!re.miss) check("rsp_index", {27'b0, rspIndex}, {27'b0, re.idx});
        if (re.op == 2'd1) begin
          check("rsp_key", {12'b0, rspKey}, {12'b0, re.key});
          check("rsp_value", {10'b0, rspValue}, {10'b0, re.value});
        end
      end
    end else if (rsp_q.size() > 0 && rsp_q[0].due <= cyc) begin
      void'(rsp_q.pop_front());
      check("rsp_valid_missing", {31'b0, rspValid}, 1);
    end
  end

  // ---------------- driver
  task automatic drive_idle();
    transRequest = 1'b0; transPage = '0; cmdValid = 1'b0;
    cmdOp = '0; cmdIndex = '0; cmdKey = '0; cmdValue = '0;
  endtask

  // Called at posedge+1; drives one cycle and predicts its outcomes.
  task automatic step(input logic treq, input logic [19:0] page, input logic cv,
                      input logic [1:0] op, input logic [4:0] idx,
                      input logic [19:0] key, input logic [21:0] val);
    logic       take_cmd, is_write, exp_acc;
    int         hit_i;
    logic [4:0] widx;
    trans_exp_t te;
    rsp_exp_t   re;
    transRequest = treq; transPage = page; cmdValid = cv;
    cmdOp = op; cmdIndex = idx; cmdKey = key; cmdValue = val;
    #1;
    take_cmd = cv && !ref_busy;
    is_write = take_cmd && op[1];
    exp_acc  = treq && !is_write;
    widx     = (op == 2'd3) ? exp_random() : idx;
    check("cmd_ready", {31'b0, cmdReady}, {31'b0, !ref_busy});
    check("trans_accept", {31'b0, transAccept}, {31'b0, exp_acc});
    check("random_index", {27'b0, randomIndex}, {27'b0, exp_random()});
    if (exp_acc) begin
      hit_i = ref_lookup(page);
      te.due   = cyc + 1;
      te.miss  = (hit_i < 0);
      te.frame = (hit_i < 0) ? 20'h0 : ref_vals[hit_i][21:2];
      te.w     = (hit_i < 0) ? 1'b0 : ref_vals[hit_i][1];
      te.v     = (hit_i < 0) ? 1'b0 : ref_vals[hit_i][0];
      trans_q.push_back(te);
    end
    if (take_cmd) begin
      re.due   = cyc + 1;
      re.op    = op;
      re.miss  = 1'b0;
      re.key   = '0;
      re.value = '0;
      re.idx   = idx;
      if (op == 2'd0) begin
        hit_i   = ref_lookup(key);
        re.miss = (hit_i < 0);
        re.idx  = (hit_i < 0) ? 5'd0 : 5'(hit_i);
      end else if (op == 2'd1) begin
        re.key   = ref_keys[idx];
        re.value = ref_vals[idx];
      end else begin
        re.idx = widx;
      end
      rsp_q.push_back(re);
    end
    @(posedge clock); #1;
    ref_busy = take_cmd;
    if (is_write) begin
      ref_keys[widx] = key;
      ref_vals[widx] = val;
    end
    drive_idle();
  endtask

  task automatic idle_step();
    step(1'b0, 20'h0, 1'b0, 2'd0, 5'd0, 20'h0, 22'h0);
  endtask

  // Called at posedge+1; reset drops anything still pending.
  task automatic do_reset(input int n);
    drive_idle();
    reset = 1'b1;
    trans_q.delete();
    rsp_q.delete();
    #1;
    check("rst_rsp_valid", {31'b0, rspValid}, 0);
    check("rst_trans_done", {31'b0, transDone}, 0);
    check("rst_write_enable", {31'b0, vmWriteEnable2}, 0);
    repeat (n) @(posedge clock);
    #1;
    reset = 1'b0;
    ref_busy = 1'b0;
    for (int i = 0; i < 32; i++) ref_keys[i] = 20'hC0000;
    #1;
    check("post_rst_cmd_ready", {31'b0, cmdReady}, 1);
    check("post_rst_rsp_valid", {31'b0, rspValid}, 0);
    check("post_rst_trans_done", {31'b0, transDone}, 0);
    check("post_rst_random", {27'b0, randomIndex}, 31);
    @(posedge clock); #1;
  endtask

  logic [19:0] pool [8];

  initial begin
    pool[0] = 20'h12345; pool[1] = 20'h00042; pool[2] = 20'h55555; pool[3] = 20'h00043;
    pool[4] = 20'h0AAAA; pool[5] = 20'hFFFFF; pool[6] = 20'h00000; pool[7] = 20'h00007;
    for (int i = 0; i < 32; i++) begin
      vm_mem[i]   = 22'h0;
      ref_vals[i] = 22'h0;
      ref_keys[i] = 20'hC0000;
    end
    ref_busy = 1'b0;
    drive_idle();
    reset = 1'b1;
    @(posedge clock); #1;
    do_reset(2);

    // Counter sweep 31..4 then wrap, with nothing else happening.
    repeat (30) idle_step();

    // Indexed write then a hitting translation.
    step(1'b0, 20'h0, 1'b1, 2'd2, 5'd7, 20'h12345, {20'hABCDE, 1'b1, 1'b1});
    idle_step();
    step(1'b1, 20'h12345, 1'b0, 2'd0, 5'd0, 20'h0, 22'h0);
    step(1'b1, 20'h55555, 1'b0, 2'd0, 5'd0, 20'h0, 22'h0);
    idle_step();

    // Duplicate keys: the lower index wins the probe.
    step(1'b0, 20'h0, 1'b1, 2'd2, 5'd9, 20'h00042, {20'h11111, 1'b0, 1'b1});
    idle_step();
    step(1'b0, 20'h0, 1'b1, 2'd2, 5'd3, 20'h00042, {20'h22222, 1'b1, 1'b0});
    idle_step();
    step(1'b0, 20'h0, 1'b1, 2'd0, 5'd0, 20'h00042, 22'h0);
    idle_step();
    step(1'b0, 20'h0, 1'b1, 2'd0, 5'd0, 20'h00043, 22'h0);
    step(1'b1, 20'h00042, 1'b0, 2'd0, 5'd0, 20'h0, 22'h0);

    // Write and translate the same page in the commit cycle, then retry.
    step(1'b1, 20'h0AAAA, 1'b1, 2'd2, 5'd12, 20'h0AAAA, {20'h33333, 1'b1, 1'b1});
    step(1'b1, 20'h0AAAA, 1'b0, 2'd0, 5'd0, 20'h0, 22'h0);
    idle_step();

    // Random write and an indexed read back.
    step(1'b0, 20'h0, 1'b1, 2'd3, 5'd0, 20'hFFFFF, {20'h44444, 1'b0, 1'b1});
    idle_step();
    step(1'b1, 20'hFFFFF, 1'b1, 2'd1, 5'd7, 20'h0, 22'h0);
    idle_step();

    // Reset while a READ is waiting for its data.
    step(1'b0, 20'h0, 1'b1, 2'd1, 5'd7, 20'h0, 22'h0);
    do_reset(1);

    for (int n = 0; n < 600; n++) begin
      step(1'($urandom_range(0, 1)), pool[$urandom_range(0, 7)],
           ($urandom_range(0, 2) == 0), 2'($urandom_range(0, 3)), 5'($urandom_range(0, 31)),
           pool[$urandom_range(0, 7)], 22'($urandom));
    end
    repeat (3) idle_step();
    check("trans_q_drained", trans_q.size(), 0);
    check("rsp_q_drained", rsp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
